// File: rtl/dart_match.sv
// dart_match: two-player countdown dart scorekeeper with bust and exact-finish rules
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   start                 start/restart a game (honoured in IDLE or DONE)
//   throw_valid/throw_pts throw result from the scorer (0..3 points)
//   throw_ready           a throw is accepted this cycle (PLAY only)
//   score0/score1         remaining score per player
//   cur_player/throw_idx  whose turn it is and throws taken this turn
//   bust                  one-cycle pulse after a bust
//   game_over/winner      game finished and which player finished it
module dart_match #(
    parameter int START_SCORE     = 15,
    parameter int SCORE_W         = 5,
    parameter int THROWS_PER_TURN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               throw_valid,
    input  logic [1:0]         throw_pts,
    output logic               throw_ready,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               cur_player,
    output logic [1:0]         throw_idx,
    output logic               bust,
    output logic               game_over,
    output logic               winner
);
    typedef enum logic [1:0] {IDLE, PLAY, SWITCH, DONE} stateT;
    localparam logic [SCORE_W-1:0] START   = SCORE_W'(START_SCORE);
    localparam logic [1:0]         LAST_IDX = 2'(THROWS_PER_TURN - 1);
    stateT state, stateNext;
    logic [SCORE_W-1:0] snap, snapNext, score0Next, score1Next, curScore, pts, newScore;
    logic curNext, bustNext, overNext, winnerNext, scoreWr;
    logic [1:0] idxNext;
    assign throw_ready = (state == PLAY);
    assign curScore    = cur_player ? score1 : score0;
    assign pts         = SCORE_W'(throw_pts);
    always_comb begin
        stateNext  = state;
        snapNext   = snap;
        curNext    = cur_player;
        idxNext    = throw_idx;
        bustNext   = 1'b0;
        overNext   = game_over;
        winnerNext = winner;
        scoreWr    = 1'b0;
        newScore   = curScore;
        score0Next = score0;
        score1Next = score1;
        case (state)
            IDLE, DONE: if (start) begin
                stateNext  = PLAY;
                score0Next = START;
                score1Next = START;
                snapNext   = START;
                curNext    = 1'b0;
                idxNext    = 2'd0;
                overNext   = 1'b0;
                winnerNext = 1'b0;
            end
            PLAY: if (throw_valid) begin
                scoreWr = 1'b1;
                // Compare before subtracting so the score can never wrap.
                if (pts > curScore) begin
                    newScore  = snap;
                    bustNext  = 1'b1;
                    idxNext   = 2'd0;
                    stateNext = SWITCH;
                end else if (pts == curScore) begin
                    newScore   = '0;
                    overNext   = 1'b1;
                    winnerNext = cur_player;
                    stateNext  = DONE;
                end else begin
                    newScore  = curScore - pts;
                    idxNext   = (throw_idx == LAST_IDX) ? 2'd0 : throw_idx + 2'd1;
                    stateNext = (throw_idx == LAST_IDX) ? SWITCH : PLAY;
                end
            end
            SWITCH: begin
                curNext   = ~cur_player;
                idxNext   = 2'd0;
                // The incoming player's score is the bust-restore point for its turn.
                snapNext  = cur_player ? score0 : score1;
                stateNext = PLAY;
            end
            default: stateNext = IDLE;
        endcase
        if (scoreWr && !cur_player) score0Next = newScore;
        if (scoreWr &&  cur_player) score1Next = newScore;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            score0     <= START;
            score1     <= START;
            snap       <= START;
            cur_player <= 1'b0;
            throw_idx  <= 2'd0;
            bust       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= stateNext;
            score0     <= score0Next;
            score1     <= score1Next;
            snap       <= snapNext;
            cur_player <= curNext;
            throw_idx  <= idxNext;
            bust       <= bustNext;
            game_over  <= overNext;
            winner     <= winnerNext;
        end
    end
endmodule

// File: tb/tb_dart_match.sv
// tb_dart_match: scoreboard bench for dart_match, one instance at START_SCORE 15 and one at 5
module tb_dart_match;
    localparam int S0 = 0, S1 = 1, CUR = 2, IDX = 3, RDY = 4, BST = 5, OVR = 6, WIN = 7;
    typedef struct {
        string tag;
        int    d;
        int    f;
        int    v;
    } expT;
    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       startS[2];
    logic       tvS[2];
    logic [1:0] tpS[2];
    logic       readyS[2];
    logic [4:0] score0S[2];
    logic [4:0] score1S[2];
    logic       curS[2];
    logic [1:0] idxS[2];
    logic       bustS[2];
    logic       overS[2];
    logic       winS[2];
    expT        sb[$];
    int         compared = 0;
    int         mismatched = 0;
    always #5 clk = ~clk;
    dart_match #(.START_SCORE(15), .SCORE_W(5), .THROWS_PER_TURN(3)) u0 (
        .clk(clk), .rst_n(rstN), .start(startS[0]), .throw_valid(tvS[0]), .throw_pts(tpS[0]),
        .throw_ready(readyS[0]), .score0(score0S[0]), .score1(score1S[0]), .cur_player(curS[0]),
        .throw_idx(idxS[0]), .bust(bustS[0]), .game_over(overS[0]), .winner(winS[0])
    );
    dart_match #(.START_SCORE(5), .SCORE_W(5), .THROWS_PER_TURN(3)) u1 (
        .clk(clk), .rst_n(rstN), .start(startS[1]), .throw_valid(tvS[1]), .throw_pts(tpS[1]),
        .throw_ready(readyS[1]), .score0(score0S[1]), .score1(score1S[1]), .cur_player(curS[1]),
        .throw_idx(idxS[1]), .bust(bustS[1]), .game_over(overS[1]), .winner(winS[1])
    );
    task automatic checkVal(input string tag, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask
    function automatic int obs(input int d, input int f);
        case (f)
            S0:      return int'(score0S[d]);
            S1:      return int'(score1S[d]);
            CUR:     return int'(curS[d]);
            IDX:     return int'(idxS[d]);
            RDY:     return int'(readyS[d]);
            BST:     return int'(bustS[d]);
            OVR:     return int'(overS[d]);
            default: return int'(winS[d]);
        endcase
    endfunction
    task automatic ex(input string tag, input int d, input int f, input int v);
        expT e;
        e.tag = tag;
        e.d   = d;
        e.f   = f;
        e.v   = v;
        sb.push_back(e);
    endtask
    task automatic drive(input int d, input logic st, input logic tv, input logic [1:0] tp);
        startS[d] = st;
        tvS[d]    = tv;
        tpS[d]    = tp;
    endtask
    task automatic tick();
        expT e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkVal($sformatf("u%0d.%s", e.d, e.tag), obs(e.d, e.f), e.v);
        end
    endtask
    initial begin
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        tick();
        ex("rst.s0", 0, S0, 15); ex("rst.s1", 0, S1, 15); ex("rst.cur", 0, CUR, 0);
        ex("rst.rdy", 0, RDY, 0); ex("rst.over", 0, OVR, 0); ex("rst.s0", 1, S0, 5);
        tick();
        rstN = 1'b1;
        ex("idle.rdy", 0, RDY, 0);
        tick();
        drive(0, 1, 0, 0);
        ex("start.rdy", 0, RDY, 1); ex("start.s0", 0, S0, 15); ex("start.idx", 0, IDX, 0);
        tick();
        drive(0, 0, 1, 3);
        ex("t1.s0", 0, S0, 12); ex("t1.idx", 0, IDX, 1); ex("t1.s1", 0, S1, 15);
        tick();
        drive(0, 1, 0, 0);
        ex("midstart.s0", 0, S0, 12); ex("midstart.idx", 0, IDX, 1); ex("midstart.rdy", 0, RDY, 1);
        tick();
        drive(0, 0, 1, 2);
        ex("t2.s0", 0, S0, 10); ex("t2.idx", 0, IDX, 2);
        tick();
        drive(0, 0, 1, 1);
        ex("t3.s0", 0, S0, 9); ex("t3.idx", 0, IDX, 0); ex("sw.rdy", 0, RDY, 0); ex("sw.cur", 0, CUR, 0);
        tick();
        drive(0, 0, 1, 3);
        ex("hold.rdy", 0, RDY, 1); ex("hold.cur", 0, CUR, 1); ex("hold.s1", 0, S1, 15); ex("hold.s0", 0, S0, 9);
        tick();
        ex("p1t1.s1", 0, S1, 12); ex("p1t1.idx", 0, IDX, 1); ex("p1t1.s0", 0, S0, 9);
        tick();
        drive(0, 0, 0, 0);
        rstN = 1'b0;
        ex("rst2.s1", 0, S1, 15); ex("rst2.cur", 0, CUR, 0);
        tick();
        rstN = 1'b1;
        drive(0, 1, 0, 0);
        tick();
        drive(0, 0, 1, 3);
        ex("pre.s0", 0, S0, 12);
        tick();
        rstN = 1'b0;
        ex("midrst.s0", 0, S0, 15); ex("midrst.rdy", 0, RDY, 0); ex("midrst.idx", 0, IDX, 0);
        ex("midrst.cur", 0, CUR, 0); ex("midrst.over", 0, OVR, 0); ex("midrst.bust", 0, BST, 0);
        tick();
        rstN = 1'b1;
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        ex("b.start.rdy", 1, RDY, 1); ex("b.start.s0", 1, S0, 5); ex("b.start.s1", 1, S1, 5);
        tick();
        drive(1, 0, 1, 3);
        ex("b.t1.s0", 1, S0, 2); ex("b.t1.bust", 1, BST, 0);
        tick();
        ex("b.t2.bust", 1, BST, 1); ex("b.t2.s0", 1, S0, 5); ex("b.t2.rdy", 1, RDY, 0); ex("b.t2.idx", 1, IDX, 0);
        tick();
        drive(1, 0, 0, 0);
        ex("b.sw.bust", 1, BST, 0); ex("b.sw.cur", 1, CUR, 1); ex("b.sw.rdy", 1, RDY, 1); ex("b.sw.s0", 1, S0, 5);
        tick();
        drive(1, 0, 1, 3);
        ex("f1.t1.s1", 1, S1, 2); ex("f1.t1.s0", 1, S0, 5);
        tick();
        drive(1, 0, 1, 2);
        ex("f1.s1", 1, S1, 0); ex("f1.over", 1, OVR, 1); ex("f1.win", 1, WIN, 1); ex("f1.rdy", 1, RDY, 0);
        tick();
        drive(1, 0, 1, 1);
        ex("done.s0", 1, S0, 5); ex("done.s1", 1, S1, 0); ex("done.over", 1, OVR, 1); ex("done.win", 1, WIN, 1);
        tick();
        ex("done2.s0", 1, S0, 5); ex("done2.rdy", 1, RDY, 0);
        tick();
        drive(1, 1, 0, 0);
        ex("rs.s0", 1, S0, 5); ex("rs.s1", 1, S1, 5); ex("rs.over", 1, OVR, 0);
        ex("rs.win", 1, WIN, 0); ex("rs.rdy", 1, RDY, 1); ex("rs.cur", 1, CUR, 0);
        tick();
        drive(1, 0, 1, 3);
        ex("f0.t1.s0", 1, S0, 2);
        tick();
        drive(1, 0, 1, 2);
        ex("f0.s0", 1, S0, 0); ex("f0.over", 1, OVR, 1); ex("f0.win", 1, WIN, 0); ex("f0.s1", 1, S1, 5);
        tick();
        drive(1, 1, 0, 0);
        ex("rs2.s0", 1, S0, 5); ex("rs2.over", 1, OVR, 0); ex("rs2.rdy", 1, RDY, 1);
        tick();
        drive(1, 0, 1, 0);
        ex("z1.s0", 1, S0, 5); ex("z1.idx", 1, IDX, 1);
        tick();
        ex("z2.idx", 1, IDX, 2);
        tick();
        ex("z3.idx", 1, IDX, 0); ex("z3.rdy", 1, RDY, 0); ex("z3.bust", 1, BST, 0);
        tick();
        drive(1, 0, 0, 0);
        ex("z.sw.cur", 1, CUR, 1); ex("z.sw.rdy", 1, RDY, 1);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
